tb_img_process: RTL and testbench

Self-contained image-processing harness. It generates a deterministic AXI4-Stream video test pattern and passes it through a 1-stage threshold (binarize) pipeline. The result is driven on an AXI4-Stream master port, and an on-board checker verifies frame geometry and data. It sits under the top-level simulation/bring-up wrapper as the image-path exerciser, clocked from the 100 MHz domain.

---
 rtl/tb_img_process.sv | 130 +++++++++++++
 tb/tb_tb_img_process.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tb_img_process.sv
// tb_img_process: test-pattern generator, threshold stage and output checker
module tb_img_process #(
    parameter int IMG_WIDTH  = 2560,
    parameter int IMG_HEIGHT = 1440,
    parameter int DATA_WIDTH = 8,
    parameter int THRESH     = 128,
    parameter int FRAME_GAP  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [15:0]           frame_cnt,
    output logic                  err,
    output logic                  busy
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int GW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
    localparam logic [XW-1:0]         X_MAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]         Y_MAX = YW'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0]         GAP   = GW'(FRAME_GAP);
    localparam logic [DATA_WIDTH-1:0] TH    = DATA_WIDTH'(THRESH);

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [7:0] f);
        return DATA_WIDTH'(x) + DATA_WIDTH'(y) + DATA_WIDTH'(f);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] binarize(input logic [DATA_WIDTH-1:0] p);
        return (p >= TH) ? {DATA_WIDTH{1'b1}} : '0;
    endfunction

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [7:0]    r_f;
    logic [GW-1:0] r_gap;
    logic          r_active;
    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [7:0]    r_cf;
    logic          w_gen_valid;
    logic          w_stage_ready;
    logic          w_gen_hs;
    logic          w_gen_eol;
    logic          w_gen_eof;
    logic          w_out_hs;
    logic          w_chk_eol;
    logic          w_chk_eof;
    logic          w_bad;

    // a frame may start only from idle with enable high and the gap drained; once started it runs to completion
    assign w_gen_valid   = r_active | (enable & (r_gap == '0));
    assign w_stage_ready = ~m_axis_tvalid | m_axis_tready;
    assign w_gen_hs      = w_gen_valid & w_stage_ready;
    assign w_gen_eol     = (r_x == X_MAX);
    assign w_gen_eof     = w_gen_eol & (r_y == Y_MAX);
    assign w_out_hs      = m_axis_tvalid & m_axis_tready;
    assign w_chk_eol     = (r_col == X_MAX);
    assign w_chk_eof     = w_chk_eol & (r_row == Y_MAX);
    assign w_bad         = (m_axis_tuser != ((r_col == '0) && (r_row == '0)))
                         | (m_axis_tlast != w_chk_eol)
                         | (m_axis_tdata != binarize(pattern(r_col, r_row, r_cf)));
    assign busy          = r_active | m_axis_tvalid;

    // generator position, frame index and inter-frame gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_f      <= '0;
            r_gap    <= '0;
            r_active <= 1'b0;
        end else begin
            if (r_gap != '0)
                r_gap <= r_gap - 1'b1;
            if (w_gen_hs) begin
                r_x <= w_gen_eol ? '0 : r_x + 1'b1;
                if (w_gen_eol)
                    r_y <= w_gen_eof ? '0 : r_y + 1'b1;
                if (w_gen_eof) begin
                    r_f   <= r_f + 1'b1;
                    r_gap <= GAP;
                end
            end
            r_active <= (w_gen_hs & w_gen_eof) ? 1'b0 : w_gen_valid;
        end
    end

    // single threshold register stage; holds its beat while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (w_stage_ready) begin
            m_axis_tvalid <= w_gen_valid;
            if (w_gen_valid) begin
                m_axis_tdata <= binarize(pattern(r_x, r_y, r_f));
                m_axis_tuser <= (r_x == '0) && (r_y == '0);
                m_axis_tlast <= w_gen_eol;
            end
        end
    end

    // output checker with its own position and pattern, sticky error and frame count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col     <= '0;
            r_row     <= '0;
            r_cf      <= '0;
            frame_cnt <= '0;
            err       <= 1'b0;
        end else if (w_out_hs) begin
            r_col <= w_chk_eol ? '0 : r_col + 1'b1;
            if (w_chk_eol)
                r_row <= w_chk_eof ? '0 : r_row + 1'b1;
            if (w_chk_eof) begin
                r_cf      <= r_cf + 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (w_bad)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tb_img_process.sv
// tb_tb_img_process: randomized self-checking bench for tb_img_process
module tb_tb_img_process;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int TH  = 4;
    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        tready = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;
    logic [15:0] frame_cnt;
    logic        err;
    logic        busy;

    int total = 0;
    int bad = 0;
    int m_n = 0;
    int m_f = 0;
    int cyc = 0;
    int cyc_eof = 0;
    int cyc_sof = 0;
    int beats = 0;
    bit have_eof = 0;
    bit gap_chk = 0;
    bit rnd = 0;
    bit stall = 0;
    logic [9:0] s_beat;

    tb_img_process #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .THRESH(TH), .FRAME_GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .frame_cnt(frame_cnt), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) tready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget, input string tag);
        int i = 0;
        while (frame_cnt != target && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(frame_cnt), 32'(target));
    endtask

    task automatic wait_beat(input int n, input int budget, input string tag);
        int i = 0;
        while (m_n < n && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(m_n >= n), 32'd1);
    endtask

    // reference: beat n of frame f sits at x=n%W, y=n/W and carries (x+y+f) mod 256 binarized
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_n = 0;
            m_f = 0;
            stall = 0;
        end else begin
            if (stall) begin
                check("stall_valid", 32'(tvalid), 32'd1);
                check("stall_beat", 32'({tuser, tlast, tdata}), 32'(s_beat));
            end
            stall = tvalid & ~tready;
            s_beat = {tuser, tlast, tdata};
            if (tvalid & tready) begin
                int x, y, p;
                x = m_n % W;
                y = m_n / W;
                p = (x + y + m_f) % 256;
                check("tdata", 32'(tdata), (p >= TH) ? 32'hFF : 32'h0);
                check("tuser", 32'(tuser), 32'(m_n == 0));
                check("tlast", 32'(tlast), 32'(x == W - 1));
                if (m_n == 0) begin
                    if (gap_chk && have_eof) check("frame_gap", 32'(cyc - cyc_eof - 1), 32'(GAP));
                    cyc_sof = cyc;
                end
                beats++;
                if (m_n == W * H - 1) begin
                    m_n = 0;
                    m_f = (m_f + 1) % 256;
                    cyc_eof = cyc;
                    have_eof = 1;
                end else begin
                    m_n++;
                end
            end
        end
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(50);
        check("idle_valid", 32'(tvalid), 32'd0);
        check("idle_cnt", 32'(frame_cnt), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        beats = 0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_cnt(16'd1, 200, "single_cnt");
        tick(10);
        check("single_beats", 32'(beats), 32'(W * H));
        check("single_span", 32'(cyc_eof - cyc_sof), 32'(W * H - 1));
        check("single_err", 32'(err), 32'd0);
        check("single_idle", 32'(tvalid), 32'd0);
        check("single_busy", 32'(busy), 32'd0);

        beats = 0;
        have_eof = 0;
        gap_chk = 1;
        enable = 1'b1;
        wait_cnt(16'd3, 400, "cont_cnt2");
        tick(8);
        enable = 1'b0;
        wait_cnt(16'd4, 200, "cont_cnt3");
        tick(10);
        gap_chk = 0;
        check("cont_beats", 32'(beats), 32'(3 * W * H));
        check("cont_stopped", 32'(frame_cnt), 32'd4);
        check("cont_err", 32'(err), 32'd0);

        beats = 0;
        rnd = 1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_cnt(16'd5, 1000, "bp_cnt");
        rnd = 0;
        tready = 1'b1;
        tick(10);
        check("bp_beats", 32'(beats), 32'(W * H));
        check("bp_err", 32'(err), 32'd0);
        check("bp_idle", 32'(tvalid), 32'd0);

        enable = 1'b1;
        wait_beat(10, 200, "rst_reach");
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(tvalid), 32'd0);
        check("rst_data", 32'(tdata), 32'd0);
        check("rst_flags", 32'({tuser, tlast}), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b0;
        beats = 0;
        wait_beat(1, 50, "rst_restart");
        enable = 1'b0;
        wait_cnt(16'd1, 200, "rst_cnt_after");
        tick(10);
        check("rst_beats", 32'(beats), 32'(W * H));
        check("rst_err_after", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
